iir_sample_source: RTL and testbench
====================================

// Module: iir_sample_source
// PURPOSE
//  Synthesizable stimulus transmitter for the iir_filter vIn/dIn stream. It is the
//  sending end of that interface. Samples are preloaded into an internal buffer, then
//  played out with programmable idle gaps. The block also drives the b/a coefficient
//  buses. After the last sample plus a drain window it raises end_sim, which stops the
//  clock generator. It replaces a behavioural data maker in FPGA/self-checking runs.
// PARAMETERS
//  NB     12  sample width is NB+1 bits; b bus is 3*NB+1 bits, a bus is 2*NB+1 bits
//  DEPTH  64  sample buffer entries (power of two)
//  AW     6   buffer address width, log2(DEPTH)
//  DRAIN  16  idle cycles after last valid sample before end_sim (>=1)
// PORTS
//  clk      in   1        system clock, rising edge
//  rst_n    in   1        asynchronous active-low reset
//  wr_en    in   1        buffer write strobe (accepted only when busy=0)
//  wr_addr  in   AW       buffer write address
//  wr_data  in   NB+1     sample to store (two's complement)
//  len      in   AW+1     samples to play, sampled on start
//  gap      in   4        idle cycles between valid samples, sampled on start
//  b_cfg    in   3*NB+1   b coefficient vector, sampled on start
//  a_cfg    in   2*NB+1   a coefficient vector, sampled on start
//  start    in   1        single-cycle launch pulse
//  busy     out  1        high in RUN/GAP/DRAIN
//  vOut     out  1        sample valid to filter vIn
//  dOut     out  NB+1     sample data to filter dIn
//  b        out  3*NB+1   registered b coefficients to filter
//  a        out  2*NB+1   registered a coefficients to filter
//  end_sim  out  1        high in DONE
// BEHAVIOUR
//  - Reset: state=IDLE; vOut, dOut, b, a, busy, end_sim, index and gap counter all 0.
//    Buffer contents are not reset. Reset mid-run aborts immediately, with no partial drain.
//  - All outputs are registered. No backpressure: the filter accepts every vOut=1 cycle.
//  - FSM states: IDLE, RUN, GAP, DRAIN, DONE.
//  - IDLE/DONE with start=1 and len!=0: latch len_q=min(len,DEPTH), gap_q, b<=b_cfg, a<=a_cfg.
//    Set idx=0, go RUN, clear end_sim. start with len=0 is ignored and the state is unchanged.
//  - RUN: exactly one cycle, vOut=1, dOut=buf[idx]. The first valid sample appears on the
//    cycle after start. Then idx++.
//    If idx==len_q-1, go DRAIN. Else if gap_q!=0, go GAP. Else stay in RUN (back-to-back).
//  - GAP: vOut=0, dOut holds the last sample. Stay gap_q cycles, then go RUN.
//  - DRAIN: vOut=0 for DRAIN cycles, then DONE. end_sim rises on the DONE entry edge.
//  - DONE: end_sim=1 and busy=0. Hold until the next valid start or reset.
//  - b/a stay constant from start until the next start. They are never changed while busy.
//  - wr_en while busy=1 is ignored and the buffer is unchanged.
//    wr_en and start in the same IDLE cycle: the write happens; playback uses the new data.
//  - start while busy=1 is ignored.
//  - Sample period is 1+gap_q cycles. Total active cycles = len_q*(1+gap_q)-gap_q+DRAIN.
// STRUCTURE
//  - Shared header iir_tb_defs.vh holds NB, state encodings (3-bit localparams), DEPTH and AW.
//    The iir_filter testbench includes the same header.
//  - Sub-module iir_sample_ram: DEPTH x (NB+1) register array. It has a sync write port and
//    a combinational read port (addressed by idx). It has no reset.
//  - Top holds the FSM, idx/gap/drain counters and the output registers.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles -> vOut=0, dOut=0, b=0, a=0, busy=0, end_sim=0.
//  2 Load buf[0..3]=1,2,-1,0x0FFF; len=4, gap=0, start -> vOut=1 for 4 consecutive
//    cycles with dOut 1,2,0x1FFF,0x0FFF. end_sim rises exactly 16 cycles after the last valid.
//  3 len=3, gap=2 -> vOut pattern 1,0,0,1,0,0,1. dOut holds during gaps.
//    busy stays high through drain.
//  4 len=100 (>DEPTH) -> exactly 64 valid samples. len=0 start -> stays IDLE, no vOut.
//  5 During RUN, pulse wr_en to addr 5 and pulse start -> buffer unchanged and sequence
//    unchanged. After DONE, a new start clears end_sim next cycle and replays.
//  6 Assert rst_n=0 in GAP state -> all outputs 0 asynchronously.
//    After release, buffer contents are intact and replay matches scenario 2.

Source files
------------

// File: rtl/iir_sample_source_pkg.sv
// Shared definitions for the iir_filter sample source: default widths/depths
// and the playback FSM state type.
package iir_sample_source_pkg;

   localparam int unsigned SRC_NB    = 12;
   localparam int unsigned SRC_DEPTH = 64;
   localparam int unsigned SRC_AW    = 6;
   localparam int unsigned SRC_DRAIN = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP,
      ST_DRAIN,
      ST_DONE
   } src_state_t;

endpackage

// File: rtl/iir_sample_source_ram.sv
// Sample buffer: DEPTH x (NB+1) register array.
// It has a synchronous write port and a combinational read port, and no reset.
module iir_sample_ram
   import iir_sample_source_pkg::*;
#(
   parameter int unsigned NB    = SRC_NB,
   parameter int unsigned DEPTH = SRC_DEPTH,
   parameter int unsigned AW    = SRC_AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [NB:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [NB:0]   rd_data
);

   logic [NB:0] mem [DEPTH];

   // Synchronous write; contents survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Combinational read
   always_comb begin
      rd_data = mem[rd_addr];
   end

endmodule

// File: rtl/iir_sample_source.sv
// Stimulus transmitter for the iir_filter vIn/dIn stream. Samples are preloaded
// into a buffer and played out with programmable idle gaps. After a drain window,
// end_sim is raised. Coefficient buses are latched on each accepted start.
module iir_sample_source
   import iir_sample_source_pkg::*;
#(
   parameter int unsigned NB    = SRC_NB,
   parameter int unsigned DEPTH = SRC_DEPTH,
   parameter int unsigned AW    = SRC_AW,
   parameter int unsigned DRAIN = SRC_DRAIN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [NB:0]     wr_data,
   input  logic [AW:0]     len,
   input  logic [3:0]      gap,
   input  logic [3*NB:0]   b_cfg,
   input  logic [2*NB:0]   a_cfg,
   input  logic            start,
   output logic            busy,
   output logic            vOut,
   output logic [NB:0]     dOut,
   output logic [3*NB:0]   b,
   output logic [2*NB:0]   a,
   output logic            end_sim
);

   localparam int unsigned DW      = $clog2(DRAIN + 1);
   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   src_state_t    state;
   logic [AW:0]   len_q;
   logic [AW:0]   idx;
   logic [3:0]    gap_q;
   logic [3:0]    gap_cnt;
   logic [DW-1:0] drain_cnt;

   logic [AW-1:0] rd_addr;
   logic [NB:0]   rd_data;
   logic [NB:0]   first_data;
   logic          wr_ok;
   logic          start_ok;
   logic [AW:0]   len_clamped;

   iir_sample_ram #(
      .NB    (NB),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we      (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Launch/write qualification and the read address of the next sample to present.
   // A write to address 0 in the start cycle is forwarded so that playback sees the new data.
   always_comb begin
      wr_ok       = wr_en & ~busy;
      start_ok    = start & ~busy & (len != '0);
      len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
      case (state)
         ST_RUN:  rd_addr = idx[AW-1:0] + AW'(1);
         ST_GAP:  rd_addr = idx[AW-1:0];
         default: rd_addr = '0;
      endcase
      first_data = (wr_ok && (wr_addr == '0)) ? wr_data : rd_data;
   end

   // Playback FSM with registered outputs that track the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         idx       <= '0;
         gap_q     <= '0;
         gap_cnt   <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         vOut      <= 1'b0;
         dOut      <= '0;
         b         <= '0;
         a         <= '0;
         end_sim   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_ok) begin
                  len_q   <= len_clamped;
                  gap_q   <= gap;
                  b       <= b_cfg;
                  a       <= a_cfg;
                  idx     <= '0;
                  gap_cnt <= '0;
                  busy    <= 1'b1;
                  vOut    <= 1'b1;
                  dOut    <= first_data;
                  end_sim <= 1'b0;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               idx <= idx + (AW+1)'(1);
               if (idx == len_q - (AW+1)'(1)) begin
                  vOut      <= 1'b0;
                  drain_cnt <= DW'(DRAIN - 1);
                  state     <= ST_DRAIN;
               end else if (gap_q != '0) begin
                  vOut    <= 1'b0;
                  gap_cnt <= gap_q - 4'd1;
                  state   <= ST_GAP;
               end else begin
                  vOut <= 1'b1;
                  dOut <= rd_data;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  vOut  <= 1'b1;
                  dOut  <= rd_data;
                  state <= ST_RUN;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  busy    <= 1'b0;
                  end_sim <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iir_sample_source.sv
// Testbench for iir_sample_source: randomized playback runs compared cycle by
// cycle against an expected-trace model built from the stream rules.
module tb_iir_sample_source;

   localparam int unsigned NB    = 12;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;
   localparam int unsigned DRAIN = 16;

   typedef struct packed {
      logic        v;
      logic [NB:0] d;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [NB:0]   wr_data;
   logic [AW:0]   len;
   logic [3:0]    gap;
   logic [3*NB:0] b_cfg;
   logic [2*NB:0] a_cfg;
   logic          start;
   logic          busy;
   logic          vOut;
   logic [NB:0]   dOut;
   logic [3*NB:0] b;
   logic [2*NB:0] a;
   logic          end_sim;

   logic [NB:0]   mbuf [DEPTH];
   int unsigned   n_vec = 0;
   int unsigned   n_err = 0;

   always #5 clk = ~clk;

   iir_sample_source #(
      .NB    (NB),
      .DEPTH (DEPTH),
      .AW    (AW),
      .DRAIN (DRAIN)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .len     (len),
      .gap     (gap),
      .b_cfg   (b_cfg),
      .a_cfg   (a_cfg),
      .start   (start),
      .busy    (busy),
      .vOut    (vOut),
      .dOut    (dOut),
      .b       (b),
      .a       (a),
      .end_sim (end_sim)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int unsigned addr, input logic [NB:0] data);
      wr_en   = 1'b1;
      wr_addr = addr[AW-1:0];
      wr_data = data;
      mbuf[addr] = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vOut"},    64'(vOut),    64'd0);
      chk({tag, "_dOut"},    64'(dOut),    64'd0);
      chk({tag, "_b"},       64'(b),       64'd0);
      chk({tag, "_a"},       64'(a),       64'd0);
      chk({tag, "_busy"},    64'(busy),    64'd0);
      chk({tag, "_end_sim"}, 64'(end_sim), 64'd0);
   endtask

   task automatic reset_abort();
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort_rst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("abort_idle_busy", 64'(busy), 64'd0);
      chk("abort_idle_vOut", 64'(vOut), 64'd0);
   endtask

   // One playback run: launch, then follow the expected per-cycle trace to DONE
   task automatic play(input int unsigned ln, input int unsigned gp, input bit disturb,
                       input int abort_at, input bit wr0, input logic [NB:0] wr0_val);
      logic [63:0]   r;
      logic [3*NB:0] bv;
      logic [2*NB:0] av;
      int unsigned   nl;
      ev_t           q[$];

      r  = {$urandom(), $urandom()};
      bv = r[3*NB:0];
      r  = {$urandom(), $urandom()};
      av = r[2*NB:0];
      len   = ln[AW:0];
      gap   = gp[3:0];
      b_cfg = bv;
      a_cfg = av;
      start = 1'b1;
      if (wr0) begin
         wr_en   = 1'b1;
         wr_addr = '0;
         wr_data = wr0_val;
         mbuf[0] = wr0_val;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;

      nl = (ln > DEPTH) ? DEPTH : ln;
      q.delete();
      for (int unsigned k = 0; k < nl; k++) begin
         q.push_back({1'b1, mbuf[k]});
         if (k != nl - 1) begin
            repeat (gp) q.push_back({1'b0, mbuf[k]});
         end
      end
      repeat (DRAIN) q.push_back({1'b0, mbuf[nl-1]});

      chk("b_latched", 64'(b), 64'(bv));
      chk("a_latched", 64'(a), 64'(av));
      for (int i = 0; i < q.size(); i++) begin
         if (abort_at >= 0 && i == abort_at) begin
            reset_abort();
            return;
         end
         chk("vOut",    64'(vOut),    64'(q[i].v));
         chk("dOut",    64'(dOut),    64'(q[i].d));
         chk("busy",    64'(busy),    64'd1);
         chk("end_sim", 64'(end_sim), 64'd0);
         if (disturb && i == 2) begin
            wr_en   = 1'b1;
            wr_addr = AW'(5);
            wr_data = ~mbuf[5];
            start   = 1'b1;
            len     = (AW+1)'(1);
            b_cfg   = ~bv;
            a_cfg   = ~av;
         end
         tick();
         wr_en = 1'b0;
         start = 1'b0;
      end
      chk("done_vOut",    64'(vOut),    64'd0);
      chk("done_dOut",    64'(dOut),    64'(mbuf[nl-1]));
      chk("done_busy",    64'(busy),    64'd0);
      chk("done_end_sim", 64'(end_sim), 64'd1);
      chk("done_b",       64'(b),       64'(bv));
      chk("done_a",       64'(a),       64'(av));
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      len     = '0;
      gap     = '0;
      b_cfg   = '0;
      a_cfg   = '0;
      start   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      for (int unsigned i = 0; i < DEPTH; i++) begin
         logic [31:0] rv;
         rv = $urandom();
         wr(i, rv[NB:0]);
      end
      wr(0, 13'h0001);
      wr(1, 13'h0002);
      wr(2, 13'h1FFF);
      wr(3, 13'h0FFF);

      // back-to-back, gapped, clamped length
      play(4, 0, 1'b0, -1, 1'b0, '0);
      play(3, 2, 1'b0, -1, 1'b0, '0);
      play(100, 0, 1'b0, -1, 1'b0, '0);

      // zero-length start is ignored from DONE
      len   = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) begin
         chk("len0_vOut",    64'(vOut),    64'd0);
         chk("len0_busy",    64'(busy),    64'd0);
         chk("len0_end_sim", 64'(end_sim), 64'd1);
         tick();
      end

      // write and start while busy are ignored, then replay from DONE
      play(8, 1, 1'b1, -1, 1'b0, '0);
      play(8, 0, 1'b0, -1, 1'b0, '0);

      // reset in GAP, then the buffer still holds the earlier samples
      play(4, 2, 1'b0, 1, 1'b0, '0);
      play(4, 0, 1'b0, -1, 1'b0, '0);

      for (int it = 0; it < 6; it++) begin
         int unsigned nw;
         logic [31:0] rv;
         nw = $urandom_range(0, 4);
         for (int unsigned w = 0; w < nw; w++) begin
            rv = $urandom();
            wr($urandom_range(0, DEPTH - 1), rv[NB:0]);
         end
         rv = $urandom();
         play($urandom_range(1, 70), $urandom_range(0, 15), 1'b0, -1,
              1'($urandom_range(0, 1)), rv[NB:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
